// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding used by the fetch unit and decoder.
package isa_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [4:0]  OPC_HALT = 5'b00000;
  localparam logic [4:0]  OPC_NOP  = 5'b00001;
  localparam logic [15:0] NOP_WORD = {OPC_NOP, 11'b0};

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALTED} fetch_state_t;

  function automatic logic [4:0] opcode_of(input logic [15:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues imem word fetches, hands one instruction at a time to decode.
// Optional performance counters (fetch_count, squash_count) are built when FETCH_PERF_CNT_EN is defined.
//
// state  | meaning
// REQ    | presenting fetch request at pc_q
// WAIT   | request accepted, awaiting imem response (squash marks it dead)
// HOLD   | instruction offered to decode
// HALTED | HALT consumed, no fetching until a redirect
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    instr_pc_inc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        squash_count
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] redir_pc;
  logic            squash;

  assign redir_pc       = redirect_pc & ~PC_W'(1);
  assign pc_next        = pc_q + PC_W'(2);
  assign imem_req_valid = rst_n && (state == REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= REQ;
      pc_q         <= RESET_PC;
      squash       <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= INSTR_W'(NOP_WORD);
      instr_pc     <= '0;
      instr_pc_inc <= PC_W'(2);
      halted       <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) pc_q <= redir_pc;
          else if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          // A response belonging to a redirected-away fetch is discarded here.
          if (imem_rsp_valid && (redirect_valid || squash)) begin
            squash <= 1'b0;
            state  <= REQ;
            if (redirect_valid) pc_q <= redir_pc;
          end else if (redirect_valid) begin
            pc_q   <= redir_pc;
            squash <= 1'b1;
          end else if (imem_rsp_valid) begin
            instr        <= imem_rsp_data;
            instr_pc     <= pc_q;
            instr_pc_inc <= pc_next;
            pc_q         <= pc_next;
            instr_valid  <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc_q        <= redir_pc;
            state       <= REQ;
          end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (opcode_of(16'(instr)) == OPC_HALT) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= REQ;
            end
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            pc_q   <= redir_pc;
            halted <= 1'b0;
            state  <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic accept_evt;
  logic drop_evt;

  assign accept_evt = (state == HOLD) && instr_valid && instr_ready && !redirect_valid;
  assign drop_evt   = ((state == WAIT) && imem_rsp_valid && (redirect_valid || squash)) ||
                      ((state == HOLD) && redirect_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (accept_evt) fetch_count <= fetch_count + 32'd1;
      if (drop_evt && (squash_count != 16'hFFFF)) squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model and imem responder.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_inc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] squash_count;
`endif

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_inc(instr_pc_inc), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // reference model: what the fetch unit owes the outside world
  int          m_pc;
  int          m_wpc;
  logic [15:0] m_word;
  bit          m_busy, m_discard, m_have, m_stop;
  int          m_fetches, m_squashes;

  // imem responder
  logic [15:0] mem [int];
  bit          pend;
  int          pend_cnt, pend_addr, rsp_delay;
  bit          acc_seen;
  int          acc_addr;

  // last sampled DUT outputs
  bit          s_rv, s_iv, s_halted;
  logic [15:0] s_ra, s_instr, s_pc, s_inc;

  function automatic logic [15:0] word_at(int a);
    return mem.exists(a) ? mem[a] : 16'h0800;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_wpc = 0; m_word = 16'h0800;
    m_busy = 0; m_discard = 0; m_have = 0; m_stop = 0;
    m_fetches = 0; m_squashes = 0;
  endtask

  task automatic count_squash();
    if (m_squashes < 65535) m_squashes++;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      if (m_have) begin m_have = 0; count_squash(); end
      m_stop = 0;
      if (m_busy) begin
        if (imem_rsp_valid) begin m_busy = 0; m_discard = 0; count_squash(); end
        else m_discard = 1;
      end
      m_pc = int'(redirect_pc) & 32'hFFFE;
    end else if (m_have) begin
      if (instr_ready) begin
        m_have = 0;
        m_fetches++;
        if ((m_word >> 11) == 0) m_stop = 1;
      end
    end else if (m_busy) begin
      if (imem_rsp_valid) begin
        m_busy = 0;
        if (m_discard) begin m_discard = 0; count_squash(); end
        else begin
          m_have = 1; m_word = imem_rsp_data; m_wpc = m_pc;
          m_pc = (m_pc + 2) % 65536;
        end
      end
    end else if (!m_stop && imem_req_ready) begin
      m_busy = 1;
    end
  endtask

  task automatic cycle();
    bit exp_rv;
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word_at(pend_addr); pend = 0;
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 16'hDEAD;
      if (pend) pend_cnt--;
    end
    if (!rst_n) model_reset();
    #2;
    exp_rv = rst_n && !m_busy && !m_have && !m_stop && !redirect_valid;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", instr_valid, m_have);
    if (m_have) begin
      chk("instr", instr, m_word);
      chk("instr_pc", instr_pc, m_wpc);
      chk("instr_pc_inc", instr_pc_inc, (m_wpc + 2) % 65536);
    end
    chk("halted", halted, m_stop);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetches);
    chk("squash_count", squash_count, m_squashes);
`endif
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_iv = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_inc = instr_pc_inc; s_halted = halted;
    acc_seen = imem_req_valid && imem_req_ready;
    acc_addr = int'(imem_req_addr);
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    if (acc_seen) begin pend = 1; pend_cnt = rsp_delay; pend_addr = acc_addr; end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(int max, string name);
    int n = 0;
    do begin cycle(); n++; end while (!s_iv && n < max);
    chk(name, s_iv, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int n;
    rst_n = 0; imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 1; rsp_delay = 0; pend = 0;
    model_reset();
    mem[16'h0000] = 16'h4000; mem[16'h0002] = 16'h4001; mem[16'h0004] = 16'h5000;
    mem[16'h0006] = 16'h6000; mem[16'h0040] = 16'h0000; mem[16'h0100] = 16'h0003;
    mem[16'h0200] = 16'h7000; mem[16'hFFFE] = 16'h4242;
    @(negedge clk);

    // reset values
    cycle(); cycle();
    chk("rst_req_valid", s_rv, 0); chk("rst_instr_valid", s_iv, 0);
    chk("rst_instr", s_instr, 16'h0800); chk("rst_instr_pc", s_pc, 0); chk("rst_halted", s_halted, 0);

    // back-to-back fetch, one instruction per 3 cycles
    rst_n = 1;
    cycle(); chk("t1_req0_valid", s_rv, 1); chk("t1_req0_addr", s_ra, 16'h0000);
    cycle(); chk("t1_wait_iv", s_iv, 0);
    cycle(); chk("t1_iv0", s_iv, 1); chk("t1_instr0", s_instr, 16'h4000);
    chk("t1_pc0", s_pc, 16'h0000); chk("t1_inc0", s_inc, 16'h0002);
    cycle(); chk("t1_req1_valid", s_rv, 1); chk("t1_req1_addr", s_ra, 16'h0002);
    cycle();
    cycle(); chk("t1_iv1", s_iv, 1); chk("t1_instr1", s_instr, 16'h4001);
    chk("t1_pc1", s_pc, 16'h0002); chk("t1_inc1", s_inc, 16'h0004);

    // decode backpressure for 5 cycles in HOLD
    instr_ready = 0;
    wait_valid(10, "t2_valid");
    chk("t2_instr", s_instr, 16'h5000); chk("t2_pc", s_pc, 16'h0004);
    for (int i = 1; i < 5; i++) begin
      cycle();
      chk("t2_stable_instr", s_instr, 16'h5000); chk("t2_stable_pc", s_pc, 16'h0004);
      chk("t2_no_req", s_rv, 0);
    end
    instr_ready = 1;
    cycle();
    rsp_delay = 2;
    cycle(); chk("t2_next_valid", s_rv, 1); chk("t2_next_addr", s_ra, 16'h0006);

    // redirect while waiting on a slow response
    redirect_valid = 1; redirect_pc = 16'h0041;
    cycle(); chk("t3_redir_mask", s_rv, 0);
    redirect_valid = 0; rsp_delay = 0; seen = 0; n = 0;
    do begin cycle(); if (s_iv) seen = 1; n++; end while (!s_rv && n < 10);
    chk("t3_no_instr", seen, 0); chk("t3_req_valid", s_rv, 1);
    chk("t3_req_addr", s_ra, 16'h0040); chk("t3_latency", n, 3);

    // HALT then recovery by redirect
    wait_valid(10, "t4_valid");
    chk("t4_instr", s_instr, 16'h0000);
    cycle(); chk("t4_halted", s_halted, 1); chk("t4_iv", s_iv, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin cycle(); if (s_rv) n++; end
    chk("t4_no_req", n, 0); chk("t4_still_halted", s_halted, 1);
    redirect_valid = 1; redirect_pc = 16'h0100;
    cycle(); chk("t4_redir_mask", s_rv, 0);
    redirect_valid = 0; instr_ready = 0;
    cycle(); chk("t4_unhalted", s_halted, 0); chk("t4_req_valid", s_rv, 1);
    chk("t4_req_addr", s_ra, 16'h0100);

    // redirect voids a HALT handshake in the same cycle
    wait_valid(10, "t5_valid");
    chk("t5_instr", s_instr, 16'h0003);
    instr_ready = 1; redirect_valid = 1; redirect_pc = 16'h0200; imem_req_ready = 0;
    cycle();
    redirect_valid = 0;
    cycle(); chk("t5_not_halted", s_halted, 0); chk("t5_iv", s_iv, 0);
    chk("t5_req_valid", s_rv, 1); chk("t5_req_addr", s_ra, 16'h0200);

    // PC wrap at top of address space, odd redirect target
    redirect_valid = 1; redirect_pc = 16'hFFFF;
    cycle(); chk("t6_redir_mask", s_rv, 0);
    redirect_valid = 0; imem_req_ready = 1;
    cycle(); chk("t6_req_valid", s_rv, 1); chk("t6_req_addr", s_ra, 16'hFFFE);
    wait_valid(10, "t6_valid");
    chk("t6_instr", s_instr, 16'h4242); chk("t6_pc", s_pc, 16'hFFFE); chk("t6_inc", s_inc, 16'h0000);
    rsp_delay = 2;
    cycle(); chk("t6_wrap_valid", s_rv, 1); chk("t6_wrap_addr", s_ra, 16'h0000);

    // reset pulse mid-WAIT, stale response lands in REQ
    rst_n = 0;
    cycle(); chk("t7_rst_iv", s_iv, 0); chk("t7_rst_rv", s_rv, 0);
    chk("t7_rst_halted", s_halted, 0); chk("t7_rst_instr", s_instr, 16'h0800);
    rst_n = 1; imem_req_ready = 0; seen = 0;
    for (int i = 0; i < 3; i++) begin cycle(); if (s_iv) seen = 1; end
    chk("t7_stale_ignored", seen, 0); chk("t7_req_valid", s_rv, 1); chk("t7_req_addr", s_ra, 16'h0000);
    rsp_delay = 0; imem_req_ready = 1;
    wait_valid(10, "t7_valid");
    chk("t7_instr", s_instr, 16'h4000); chk("t7_pc", s_pc, 16'h0000);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
